// File: rtl/target_gen_pkg.sv
// Shared constants and payload types for the snake-game target generator.
package target_gen_pkg;

  localparam int unsigned X_CELLS  = 160;
  localparam int unsigned Y_CELLS  = 120;
  localparam int unsigned ADDR_X_W = 8;
  localparam int unsigned ADDR_Y_W = 7;

  localparam logic [ADDR_X_W-1:0] X_SEED_DEF = 8'hA5;
  localparam logic [ADDR_Y_W-1:0] Y_SEED_DEF = 7'h3C;
  localparam int unsigned         X_INIT_DEF = 80;
  localparam int unsigned         Y_INIT_DEF = 60;

  // Feedback tap masks: x^8+x^6+x^5+x^4+1 and x^7+x^6+1
  localparam logic [ADDR_X_W-1:0] X_TAPS = 8'hB8;
  localparam logic [ADDR_Y_W-1:0] Y_TAPS = 7'h60;

  typedef struct packed {
    logic [ADDR_X_W-1:0] x;
    logic [ADDR_Y_W-1:0] y;
  } target_t;

endpackage

// File: rtl/lfsr.sv
// Free-running Fibonacci LFSR; feedback is the XOR of the tapped bits.
module lfsr #(
  parameter int unsigned      WIDTH = 8,
  parameter logic [WIDTH-1:0] TAPS  = WIDTH'(1),
  parameter logic [WIDTH-1:0] SEED  = WIDTH'(1)
) (
  input  logic             CLK,
  input  logic             RESET,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] state = SEED;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state <= SEED;
    end else begin
      state <= {state[WIDTH-2:0], ^(state & TAPS)};
    end
  end

  assign q = state;

endmodule

// File: rtl/target_gen.sv
// Snake-game target generator: latches a folded pseudo-random cell on each
// rising edge of TARGET_REACHED.
module target_gen
  import target_gen_pkg::*;
#(
  parameter int unsigned         X_CELLS_P = X_CELLS,
  parameter int unsigned         Y_CELLS_P = Y_CELLS,
  parameter logic [ADDR_X_W-1:0] X_SEED    = X_SEED_DEF,
  parameter logic [ADDR_Y_W-1:0] Y_SEED    = Y_SEED_DEF,
  parameter int unsigned         X_INIT    = X_INIT_DEF,
  parameter int unsigned         Y_INIT    = Y_INIT_DEF
) (
  input  logic                CLK,
  input  logic                RESET,
  input  logic                TARGET_REACHED,
  output logic [ADDR_X_W-1:0] TARGET_ADDR_X,
  output logic [ADDR_Y_W-1:0] TARGET_ADDR_Y
);

  localparam target_t TARGET_RST = '{x: ADDR_X_W'(X_INIT), y: ADDR_Y_W'(Y_INIT)};

  logic [ADDR_X_W-1:0] lfsr_x;
  logic [ADDR_Y_W-1:0] lfsr_y;
  target_t             cand_c;
  logic                rise_c;
  logic                reached_d = 1'b0;
  target_t             target_q  = TARGET_RST;

  lfsr #(.WIDTH(ADDR_X_W), .TAPS(X_TAPS), .SEED(X_SEED)) u_lfsr_x (
    .CLK  (CLK),
    .RESET(RESET),
    .q    (lfsr_x)
  );

  lfsr #(.WIDTH(ADDR_Y_W), .TAPS(Y_TAPS), .SEED(Y_SEED)) u_lfsr_y (
    .CLK  (CLK),
    .RESET(RESET),
    .q    (lfsr_y)
  );

  // A single conditional subtract suffices: LFSR range is below twice the grid size
  always_comb begin
    cand_c.x = lfsr_x;
    cand_c.y = lfsr_y;
    if (lfsr_x >= ADDR_X_W'(X_CELLS_P)) cand_c.x = lfsr_x - ADDR_X_W'(X_CELLS_P);
    if (lfsr_y >= ADDR_Y_W'(Y_CELLS_P)) cand_c.y = lfsr_y - ADDR_Y_W'(Y_CELLS_P);
  end

  assign rise_c = TARGET_REACHED & ~reached_d;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      reached_d <= 1'b0;
      target_q  <= TARGET_RST;
    end else begin
      reached_d <= TARGET_REACHED;
      if (rise_c) target_q <= cand_c;
    end
  end

  assign TARGET_ADDR_X = target_q.x;
  assign TARGET_ADDR_Y = target_q.y;

endmodule

// File: tb/tb_target_gen.sv
// Directed bench for target_gen with an independent cycle model of the LFSRs.
module tb_target_gen;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       tr  = 1'b0;
  logic [7:0] tx;
  logic [6:0] ty;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;
  int unsigned lfsr_err = 0;

  target_gen dut (
    .CLK           (clk),
    .RESET         (rst),
    .TARGET_REACHED(tr),
    .TARGET_ADDR_X (tx),
    .TARGET_ADDR_Y (ty)
  );

  always #5 clk = ~clk;

  // Reference model: written from the polynomials directly
  logic [7:0] mx  = 8'hA5;
  logic [6:0] my  = 7'h3C;
  logic       mrd = 1'b0;
  logic [7:0] ex  = 8'd80;
  logic [6:0] ey  = 7'd60;

  function automatic logic [7:0] fold_x(input logic [7:0] v);
    return (v > 8'd159) ? v - 8'd160 : v;
  endfunction

  function automatic logic [6:0] fold_y(input logic [6:0] v);
    return (v > 7'd119) ? v - 7'd120 : v;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      mx <= 8'hA5; my <= 7'h3C; mrd <= 1'b0; ex <= 8'd80; ey <= 7'd60;
    end else begin
      mx  <= {mx[6:0], mx[7] ^ mx[5] ^ mx[4] ^ mx[3]};
      my  <= {my[5:0], my[6] ^ my[5]};
      mrd <= tr;
      if (tr && !mrd) begin
        ex <= fold_x(mx);
        ey <= fold_y(my);
      end
    end
  end

  // LFSR state tracking and the never-zero property, sampled mid-cycle
  always @(negedge clk) begin
    if (dut.u_lfsr_x.q !== mx || dut.u_lfsr_y.q !== my) lfsr_err++;
    if (dut.u_lfsr_x.q == 8'd0 || dut.u_lfsr_y.q == 7'd0) lfsr_err++;
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic check_model(input string tag);
    check_eq({tag, "_x"}, 32'(tx), 32'(ex));
    check_eq({tag, "_y"}, 32'(ty), 32'(ey));
  endtask

  task automatic do_reset();
    rst = 1'b1; tr = 1'b0;
    tick(); tick();
    rst = 1'b0;
  endtask

  // Wait until the model X (or Y) LFSR holds v, then pulse and check the folded result
  task automatic fold_case(input string tag, input bit is_y, input logic [7:0] v,
                           input logic [7:0] exp_v);
    int n = 0;
    tr = 1'b0;
    tick();
    while ((is_y ? {1'b0, my} : mx) != v && n < 300) begin
      tick(); n++;
    end
    check_eq({tag, "_wait"}, 32'(n < 300), 32'd1);
    tr = 1'b1;
    tick();
    tr = 1'b0;
    check_eq(tag, is_y ? 32'(ty) : 32'(tx), 32'(exp_v));
    check_model(tag);
  endtask

  // Fixed-timing stimulus used to check replay after reset
  task automatic replay(output logic [14:0] seq[8]);
    for (int i = 0; i < 8; i++) begin
      repeat (i + 2) tick();
      tr = 1'b1;
      tick();
      tr = 1'b0;
      seq[i] = {tx, ty};
    end
  endtask

  bit          cov_x[160];
  bit          cov_y[120];
  logic [14:0] seq_a[8];
  logic [14:0] seq_b[8];

  initial begin
    int changes;
    int ncov;
    int px;
    int py;
    int per_x;
    int per_y;
    logic [7:0] hx;
    logic [6:0] hy;

    // Reset and idle hold
    tick(); tick();
    rst = 1'b0;
    check_eq("rst_x", 32'(tx), 32'd80);
    check_eq("rst_y", 32'(ty), 32'd60);
    changes = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (tx != 8'd80 || ty != 7'd60) changes++;
    end
    check_eq("idle_hold", 32'(changes), 32'd0);

    // Single pulse
    tr = 1'b1;
    tick();
    tr = 1'b0;
    check_model("pulse");
    hx = tx; hy = ty;
    repeat (5) tick();
    check_eq("pulse_hold", 32'({tx, ty}), 32'({hx, hy}));

    // Held level gives one update; low-then-high gives another
    changes = 0;
    px = tx; py = ty;
    tr = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (i == 0) check_model("held_first");
      if (32'(tx) != 32'(px) || 32'(ty) != 32'(py)) changes++;
      px = tx; py = ty;
    end
    check_eq("held_changes", 32'(changes), 32'd1);
    tr = 1'b0;
    tick();
    check_eq("held_low_hold", 32'({tx, ty}), 32'(px * 128 + py));
    tr = 1'b1;
    tick();
    tr = 1'b0;
    check_model("retrigger");

    // Fold boundaries
    fold_case("fold_x200", 1'b0, 8'd200, 8'd40);
    fold_case("fold_x160", 1'b0, 8'd160, 8'd0);
    fold_case("fold_y125", 1'b1, 8'd125, 8'd5);
    fold_case("fold_y119", 1'b1, 8'd119, 8'd119);

    // Range sweep with random spacing
    for (int i = 0; i < 3000; i++) begin
      repeat ($urandom_range(1, 4)) tick();
      tr = 1'b1;
      tick();
      tr = 1'b0;
      if (32'(tx) != 32'(ex) || 32'(ty) != 32'(ey)) check_model("sweep");
      if (tx < 8'd160) cov_x[tx] = 1'b1;
      if (ty < 7'd120) cov_y[ty] = 1'b1;
    end
    ncov = 0;
    foreach (cov_x[i]) ncov += int'(cov_x[i]);
    check_eq("cover_x", 32'(ncov), 32'd160);
    ncov = 0;
    foreach (cov_y[i]) ncov += int'(cov_y[i]);
    check_eq("cover_y", 32'(ncov), 32'd120);

    // Reset wins over a simultaneous rise
    tr = 1'b0;
    tick();
    rst = 1'b1; tr = 1'b1;
    tick();
    rst = 1'b0; tr = 1'b0;
    check_eq("prio_x", 32'(tx), 32'd80);
    check_eq("prio_y", 32'(ty), 32'd60);

    // Replay after reset is repeatable
    do_reset();
    replay(seq_a);
    do_reset();
    replay(seq_b);
    for (int i = 0; i < 8; i++) check_eq($sformatf("replay%0d", i), 32'(seq_b[i]), 32'(seq_a[i]));
    check_model("replay_end");

    // LFSR periods measured from the reset seeds
    rst = 1'b1;
    tick();
    rst = 1'b0;
    per_x = 0; per_y = 0;
    for (int n = 1; n <= 300; n++) begin
      tick();
      if (per_x == 0 && dut.u_lfsr_x.q == 8'hA5) per_x = n;
      if (per_y == 0 && dut.u_lfsr_y.q == 7'h3C) per_y = n;
      if (per_x != 0 && per_y != 0) break;
    end
    check_eq("period_x", 32'(per_x), 32'd255);
    check_eq("period_y", 32'(per_y), 32'd127);
    check_eq("lfsr_track", 32'(lfsr_err), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
